// File: rtl/vreg_file_p.sv
// Vector register file with a per-lane-masked parallel port and a serial
// element-streaming port that walks one register (or a pair) lane by lane.
module vreg_file_p #(
    parameter int NREG  = 8,
    parameter int NLANE = 16,
    parameter int W     = 16,
    localparam int AW   = (NREG > 1) ? $clog2(NREG) : 1,
    localparam int IW   = (NLANE > 1) ? $clog2(NLANE) : 1
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic [AW-1:0]       Addr,
    input  logic [AW-1:0]       Addr2,
    input  logic                WR_p,
    input  logic                RD_p,
    input  logic [NLANE*W-1:0]  DataIn_p,
    input  logic [NLANE-1:0]    WrMask,
    output logic [NLANE*W-1:0]  DataOut_p,
    output logic [NLANE*W-1:0]  DataOut2_p,
    input  logic                Start_s,
    input  logic                Dir_s,
    input  logic [W-1:0]        DataIn_s,
    input  logic                Valid_s,
    output logic [W-1:0]        DataOut_s,
    output logic [W-1:0]        DataOut2_s,
    output logic                Valid_out_s,
    output logic                Busy_s,
    output logic                Done_s,
    output logic                Err_p
);

    typedef enum logic [1:0] {IDLE, SREAD, SWRITE, DONE} state_t;

    state_t state_q, state_d;

    logic [NREG-1:0][NLANE-1:0][W-1:0] regs_q, regs_d;
    logic [NLANE-1:0][W-1:0]           dout_q, dout_d, dout2_q, dout2_d;
    logic [NLANE-1:0][W-1:0]           din_lanes;
    logic [W-1:0]                      sdout_q, sdout_d, sdout2_q, sdout2_d;
    logic [IW-1:0]                     idx_q, idx_d;
    logic [AW-1:0]                     sa_q, sa_d, sa2_q, sa2_d;
    logic                              svld_q, svld_d, err_q, err_d;
    logic                              idx_last, wr_hit, wr_ok;

    assign din_lanes = DataIn_p;
    assign idx_last  = (idx_q == IW'(NLANE - 1));

    // A parallel write may not touch a register the serial engine owns.
    assign wr_hit = (state_q != IDLE) &&
                    ((Addr == sa_q) || ((state_q == SREAD) && (Addr == sa2_q)));
    assign wr_ok  = WR_p && !wr_hit;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q  <= IDLE;
            regs_q   <= '0;
            dout_q   <= '0;
            dout2_q  <= '0;
            sdout_q  <= '0;
            sdout2_q <= '0;
            idx_q    <= '0;
            sa_q     <= '0;
            sa2_q    <= '0;
            svld_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            regs_q   <= regs_d;
            dout_q   <= dout_d;
            dout2_q  <= dout2_d;
            sdout_q  <= sdout_d;
            sdout2_q <= sdout2_d;
            idx_q    <= idx_d;
            sa_q     <= sa_d;
            sa2_q    <= sa2_d;
            svld_q   <= svld_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (Start_s) state_d = Dir_s ? SWRITE : SREAD;
            SREAD:   if (idx_last) state_d = DONE;
            SWRITE:  if (Valid_s && idx_last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        Busy_s = (state_q != IDLE);
        Done_s = (state_q == DONE);
    end

    always_comb begin
        regs_d   = regs_q;
        dout_d   = dout_q;
        dout2_d  = dout2_q;
        sdout_d  = sdout_q;
        sdout2_d = sdout2_q;
        idx_d    = idx_q;
        sa_d     = sa_q;
        sa2_d    = sa2_q;
        svld_d   = 1'b0;
        err_d    = WR_p && wr_hit;

        if ((state_q == IDLE) && Start_s) begin
            sa_d  = Addr;
            sa2_d = Addr2;
            idx_d = '0;
        end

        // idx parks at the last lane instead of wrapping.
        if (state_q == SREAD) begin
            sdout_d  = regs_q[sa_q][idx_q];
            sdout2_d = regs_q[sa2_q][idx_q];
            svld_d   = 1'b1;
            if (!idx_last) idx_d = idx_q + 1'b1;
        end

        if ((state_q == SWRITE) && Valid_s) begin
            regs_d[sa_q][idx_q] = DataIn_s;
            if (!idx_last) idx_d = idx_q + 1'b1;
        end

        // Reads sample regs_q, so a same-cycle write is not yet visible.
        if (RD_p) begin
            dout_d  = regs_q[Addr];
            dout2_d = regs_q[Addr2];
        end

        for (int i = 0; i < NLANE; i++) begin
            if (wr_ok && WrMask[i]) regs_d[Addr][i] = din_lanes[i];
        end
    end

    assign DataOut_p   = dout_q;
    assign DataOut2_p  = dout2_q;
    assign DataOut_s   = sdout_q;
    assign DataOut2_s  = sdout2_q;
    assign Valid_out_s = svld_q;
    assign Err_p       = err_q;

endmodule

// File: tb/tb_vreg_file_p.sv
// Directed bench for vreg_file_p: a transaction-level register-file model
// is compared against every DUT output each cycle, plus literal spot checks.
module tb_vreg_file_p;
    localparam int NREG  = 8;
    localparam int NLANE = 16;
    localparam int W     = 16;
    localparam int AW    = 3;
    localparam int VW    = NLANE * W;

    logic              Clk, Rst;
    logic [AW-1:0]     Addr, Addr2;
    logic              WR_p, RD_p;
    logic [VW-1:0]     DataIn_p;
    logic [NLANE-1:0]  WrMask;
    logic [VW-1:0]     DataOut_p, DataOut2_p;
    logic              Start_s, Dir_s, Valid_s;
    logic [W-1:0]      DataIn_s, DataOut_s, DataOut2_s;
    logic              Valid_out_s, Busy_s, Done_s, Err_p;

    vreg_file_p #(.NREG(NREG), .NLANE(NLANE), .W(W)) dut (
        .Clk(Clk), .Rst(Rst), .Addr(Addr), .Addr2(Addr2),
        .WR_p(WR_p), .RD_p(RD_p), .DataIn_p(DataIn_p), .WrMask(WrMask),
        .DataOut_p(DataOut_p), .DataOut2_p(DataOut2_p),
        .Start_s(Start_s), .Dir_s(Dir_s), .DataIn_s(DataIn_s), .Valid_s(Valid_s),
        .DataOut_s(DataOut_s), .DataOut2_s(DataOut2_s), .Valid_out_s(Valid_out_s),
        .Busy_s(Busy_s), .Done_s(Done_s), .Err_p(Err_p)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int checks = 0;
    int failures = 0;
    bit chk_en = 0;

    // Model: register contents plus a serial job (mode 0 none, 1 read,
    // 2 write, 3 finishing) counted in elements transferred.
    logic [W-1:0]  mem [NREG][NLANE];
    logic [VW-1:0] m_dout, m_dout2;
    logic [W-1:0]  m_sd, m_sd2;
    bit            m_vld, m_err;
    int            m_mode, m_sa, m_sa2, m_cnt;

    task automatic chk(input string name, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic logic [VW-1:0] ramp(input logic [W-1:0] base);
        logic [VW-1:0] v;
        for (int l = 0; l < NLANE; l++) v[l*W +: W] = base + W'(l);
        return v;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < NREG; r++)
            for (int l = 0; l < NLANE; l++) mem[r][l] = '0;
        m_dout = '0; m_dout2 = '0; m_sd = '0; m_sd2 = '0;
        m_vld = 0; m_err = 0; m_mode = 0; m_sa = 0; m_sa2 = 0; m_cnt = 0;
    endtask

    task automatic model_step();
        logic [W-1:0] snap [NREG][NLANE];
        bit blocked;
        snap = mem;
        m_vld = 0;
        m_err = 0;
        blocked = (m_mode != 0) && ((int'(Addr) == m_sa) || (m_mode == 1 && int'(Addr) == m_sa2));
        if (RD_p)
            for (int l = 0; l < NLANE; l++) begin
                m_dout[l*W +: W]  = snap[Addr][l];
                m_dout2[l*W +: W] = snap[Addr2][l];
            end
        if (WR_p) begin
            if (blocked) m_err = 1;
            else for (int l = 0; l < NLANE; l++)
                if (WrMask[l]) mem[Addr][l] = DataIn_p[l*W +: W];
        end
        case (m_mode)
            0: if (Start_s) begin
                m_sa = int'(Addr); m_sa2 = int'(Addr2); m_cnt = 0;
                m_mode = Dir_s ? 2 : 1;
            end
            1: begin
                m_sd = snap[m_sa][m_cnt]; m_sd2 = snap[m_sa2][m_cnt]; m_vld = 1;
                m_cnt++;
                if (m_cnt == NLANE) m_mode = 3;
            end
            2: if (Valid_s) begin
                mem[m_sa][m_cnt] = DataIn_s;
                m_cnt++;
                if (m_cnt == NLANE) m_mode = 3;
            end
            default: m_mode = 0;
        endcase
    endtask

    always @(negedge Clk) begin
        if (chk_en) begin
            chk("dout_p",  DataOut_p,  m_dout);
            chk("dout2_p", DataOut2_p, m_dout2);
            chk("dout_s",  VW'(DataOut_s),  VW'(m_sd));
            chk("dout2_s", VW'(DataOut2_s), VW'(m_sd2));
            chk("valid_out", VW'(Valid_out_s), VW'(m_vld));
            chk("busy",  VW'(Busy_s), VW'(m_mode != 0));
            chk("done",  VW'(Done_s), VW'(m_mode == 3));
            chk("err_p", VW'(Err_p),  VW'(m_err));
        end
    end

    task automatic tick();
        @(negedge Clk);
        #1;
        model_step();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_idle();
        WR_p = 0; RD_p = 0; Start_s = 0; Dir_s = 0; Valid_s = 0;
        DataIn_p = '0; WrMask = '0; DataIn_s = '0; Addr = '0; Addr2 = '0;
    endtask

    task automatic do_reset();
        #1;
        Rst = 1;
        model_reset();
        #1;
        chk("rst_dout_p", DataOut_p, '0);
        chk("rst_dout2_p", DataOut2_p, '0);
        chk("rst_serial", VW'({DataOut_s, DataOut2_s}), '0);
        chk("rst_flags", VW'({Valid_out_s, Busy_s, Done_s, Err_p}), '0);
        @(posedge Clk);
        #2;
        Rst = 0;
    endtask

    initial begin
        int done_cnt, done_at, err_cnt;
        logic [VW-1:0] exp_v;
        logic [W-1:0] q1[$], q2[$];

        set_idle();
        Rst = 1;
        model_reset();
        @(posedge Clk);
        #2;
        Rst = 0;
        chk_en = 1;
        chk("init_busy", VW'(Busy_s), '0);

        // Serial write reg0 with a two-cycle Valid_s stall; stray Start_s ignored.
        Addr = 0; Dir_s = 1; Start_s = 1;
        tick();
        Start_s = 0;
        done_cnt = 0; done_at = -1;
        for (int i = 0; i < NLANE; i++) begin
            Valid_s = 1; DataIn_s = 16'hA000 + W'(i);
            Start_s = (i == 8); Dir_s = 0;
            tick();
            Start_s = 0;
            if (Done_s) begin done_cnt++; done_at = i; end
            if (i == 5) begin
                Valid_s = 0;
                repeat (2) begin tick(); if (Done_s) done_cnt++; end
            end
        end
        Valid_s = 0;
        repeat (2) begin tick(); if (Done_s) done_cnt++; end
        chk("wr_done_cnt", VW'(done_cnt), VW'(1));
        chk("wr_done_at", VW'(done_at), VW'(15));
        RD_p = 1; Addr = 0; Addr2 = 0;
        tick();
        RD_p = 0;
        chk("reg0_ramp", DataOut_p, ramp(16'hA000));

        // Serial read of reg0 on both ports.
        Addr = 0; Addr2 = 0; Dir_s = 0; Start_s = 1;
        tick();
        Start_s = 0;
        done_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (Valid_out_s) begin q1.push_back(DataOut_s); q2.push_back(DataOut2_s); end
            if (Done_s) done_cnt++;
        end
        chk("rd_count", VW'(q1.size()), VW'(NLANE));
        chk("rd_done_cnt", VW'(done_cnt), VW'(1));
        for (int k = 0; k < q1.size(); k++) begin
            chk("rd_elem", VW'(q1[k]), VW'(16'hA000 + W'(k)));
            chk("rd_elem2", VW'(q2[k]), VW'(16'hA000 + W'(k)));
        end

        // Masked parallel write over a known background.
        WR_p = 1; Addr = 2; WrMask = '1; DataIn_p = {NLANE{16'h5555}};
        tick();
        DataIn_p = 256'h0123456789ABCDEF; WrMask = 16'h0005;
        tick();
        WR_p = 0; RD_p = 1;
        tick();
        RD_p = 0;
        exp_v = {NLANE{16'h5555}};
        exp_v[15:0] = 16'hCDEF;
        exp_v[47:32] = 16'h4567;
        chk("mask_wr", DataOut_p, exp_v);

        // Same-cycle write and read returns old data.
        WR_p = 1; RD_p = 1; Addr = 3; WrMask = '1; DataIn_p = {NLANE{16'h1111}};
        tick();
        chk("rw_old", DataOut_p, '0);
        WR_p = 0; Addr2 = 2;
        tick();
        RD_p = 0;
        chk("rw_new", DataOut_p, {NLANE{16'h1111}});

        // Conflicting vs non-conflicting parallel writes during serial write.
        Addr = 4; Dir_s = 1; Start_s = 1;
        tick();
        Start_s = 0;
        err_cnt = 0;
        for (int i = 0; i < NLANE; i++) begin
            Valid_s = 1; DataIn_s = 16'hB000 + W'(i);
            WR_p = (i == 3) || (i == 6); WrMask = '1;
            Addr = (i == 3) ? 3'd4 : 3'd5;
            DataIn_p = (i == 3) ? {NLANE{16'hFFFF}} : {NLANE{16'h7777}};
            tick();
            WR_p = 0;
            if (Err_p) err_cnt++;
            if (i == 3) chk("err_hit", VW'(Err_p), VW'(1));
            if (i == 6) chk("err_other", VW'(Err_p), VW'(0));
        end
        Valid_s = 0;
        repeat (2) tick();
        chk("err_cnt", VW'(err_cnt), VW'(1));
        RD_p = 1; Addr = 4; Addr2 = 5;
        tick();
        RD_p = 0;
        chk("reg4_intact", DataOut_p, ramp(16'hB000));
        chk("reg5_applied", DataOut2_p, {NLANE{16'h7777}});

        // Serial read 0/4: write to SA2 rejected, then reset at idx 7.
        Addr = 0; Addr2 = 4; Dir_s = 0; Start_s = 1;
        tick();
        Start_s = 0;
        WR_p = 1; Addr = 4; WrMask = '1; DataIn_p = '1;
        tick();
        WR_p = 0;
        chk("err_sa2", VW'(Err_p), VW'(1));
        repeat (7) tick();
        chk("rd_at7", VW'(DataOut_s), VW'(16'hA007));
        set_idle();
        do_reset();

        // First posedge after release accepts Start_s.
        Addr = 6; Dir_s = 1; Start_s = 1;
        tick();
        Start_s = 0;
        chk("start_after_rst", VW'(Busy_s), VW'(1));
        for (int i = 0; i < NLANE; i++) begin
            Valid_s = 1; DataIn_s = 16'hC000 + W'(i);
            tick();
        end
        Valid_s = 0;
        repeat (2) tick();
        RD_p = 1; Addr = 0; Addr2 = 6;
        tick();
        RD_p = 0;
        chk("reg0_cleared", DataOut_p, '0);
        chk("reg6_ramp", DataOut2_p, ramp(16'hC000));
        RD_p = 1; Addr = 4; Addr2 = 5;
        tick();
        RD_p = 0;
        chk("reg4_cleared", DataOut_p, '0);
        chk("reg5_cleared", DataOut2_p, '0);
        tick();

        chk_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
